// File: rtl/frame_sequencer.sv
// Frame sequencer: paces a sample source through one frame of i_len samples, i_gap idle cycles apart.
// Latency: the first o_en can fire in the cycle after start is accepted; o_done follows the last sample by one cycle.
// Backpressure: i_ready gates o_en combinationally, and the index holds while stalled. Gap counting ignores i_ready.
//
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start/i_len/i_gap   frame request; sampled in IDLE only
//   i_abort               terminate the running frame
//   i_ready               downstream accepts a sample this cycle
//   o_en/o_sof/o_eof      sample strobe and frame markers
//   o_idx                 current sample index
//   o_busy/o_done         frame in progress / one-cycle completion pulse
//   o_aborted             last frame was aborted; cleared on the next accepted start
//   o_frame_cnt           completed (non-aborted) frames, wrapping
module frame_sequencer #(
   parameter int LEN_W  = 8,
   parameter int GAP_W  = 4,
   parameter int FCNT_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [GAP_W-1:0]  i_gap,
   input  logic              i_abort,
   input  logic              i_ready,
   output logic              o_en,
   output logic              o_sof,
   output logic              o_eof,
   output logic [LEN_W-1:0]  o_idx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_aborted,
   output logic [FCNT_W-1:0] o_frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  len_q;
   logic [GAP_W-1:0]  gap_q;
   logic [GAP_W-1:0]  gap_cnt;
   logic [FCNT_W-1:0] frame_cnt;
   logic              aborted;

   logic              en;
   logic              last;
   logic              accept;
   logic              idx_inc;
   logic              gap_load;
   logic              cnt_inc;
   logic              abort_set;

   // Compared at LEN_W bits, so the longest frame is 2^LEN_W-1 samples.
   assign last = (idx == (len_q - LEN_W'(1)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         len_q     <= '0;
         gap_q     <= '0;
         gap_cnt   <= '0;
         frame_cnt <= '0;
         aborted   <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            len_q   <= i_len;
            gap_q   <= i_gap;
            idx     <= '0;
            aborted <= 1'b0;
         end else if (idx_inc) begin
            idx <= idx + LEN_W'(1);
         end
         if (gap_load) begin
            gap_cnt <= gap_q;
         end else if (state == S_GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
         if (cnt_inc) begin
            frame_cnt <= frame_cnt + FCNT_W'(1);
         end
         if (abort_set) begin
            aborted <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state;
      en        = 1'b0;
      accept    = 1'b0;
      idx_inc   = 1'b0;
      gap_load  = 1'b0;
      cnt_inc   = 1'b0;
      abort_set = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               accept = 1'b1;
               // An empty frame completes without issuing any sample.
               if (i_len == '0) begin
                  state_d = S_DONE;
                  cnt_inc = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            o_busy = 1'b1;
            en     = i_ready & ~i_abort;
            if (i_abort) begin
               abort_set = 1'b1;
               state_d   = S_DONE;
            end else if (en) begin
               if (last) begin
                  state_d = S_DONE;
                  cnt_inc = 1'b1;
               end else begin
                  idx_inc = 1'b1;
                  if (gap_q != '0) begin
                     gap_load = 1'b1;
                     state_d  = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            o_busy = 1'b1;
            if (i_abort) begin
               abort_set = 1'b1;
               state_d   = S_DONE;
            end else if (gap_cnt == GAP_W'(1)) begin
               // Loaded with gap and left at 1: exactly gap idle cycles.
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign o_en        = en;
   assign o_sof       = en & (idx == '0);
   assign o_eof       = en & last;
   assign o_idx       = idx;
   assign o_aborted   = aborted;
   assign o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
   localparam int LEN_W  = 8;
   localparam int GAP_W  = 4;
   localparam int FCNT_W = 8;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len   = '0;
   logic [GAP_W-1:0]  gap   = '0;
   logic              abort = 1'b0;
   logic              ready = 1'b0;
   logic              o_en, o_sof, o_eof, o_busy, o_done, o_aborted;
   logic [LEN_W-1:0]  o_idx;
   logic [FCNT_W-1:0] o_frame_cnt;

   frame_sequencer #(.LEN_W(LEN_W), .GAP_W(GAP_W), .FCNT_W(FCNT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_len(len), .i_gap(gap),
      .i_abort(abort), .i_ready(ready), .o_en(o_en), .o_sof(o_sof), .o_eof(o_eof),
      .o_idx(o_idx), .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted),
      .o_frame_cnt(o_frame_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [FCNT_W-1:0] exp_cnt = '0;

   // Expected samples of the running frame: cycle offset from the start edge, index, markers.
   typedef struct {
      int off;
      int idx;
      bit sof;
      bit eof;
   } samp_t;
   samp_t sb[$];

   // Frame vectors: length, gap, and the hand-computed cycle offset of o_done.
   typedef struct {
      int len;
      int gap;
      int done_off;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run one frame from IDLE with ready held high; returns in the IDLE cycle after o_done.
   task automatic run_frame(input int l, input int g, input int done_off);
      int    off;
      bit    seen_done;
      samp_t s;
      start = 1'b1;
      len   = LEN_W'(l);
      gap   = GAP_W'(g);
      ready = 1'b1;
      for (int k = 0; k < l; k++) sb.push_back('{1 + k * (g + 1), k, k == 0, k == l - 1});
      step();
      start     = 1'b0;
      off       = 0;
      seen_done = 1'b0;
      while (!seen_done && off < done_off + 4) begin
         @(negedge clk);
         off++;
         if (o_en) begin
            if (sb.size() == 0) begin
               check("en_unexpected", 32'(o_en), 32'd0);
            end else begin
               s = sb.pop_front();
               check("en_cycle", off, s.off);
               check("idx", 32'(o_idx), s.idx);
               check("sof", 32'(o_sof), 32'(s.sof));
               check("eof", 32'(o_eof), 32'(s.eof));
            end
         end
         if (o_done) begin
            seen_done = 1'b1;
            check("done_cycle", off, done_off);
         end
         step();
      end
      if (!seen_done) check("done_timeout", 32'd0, 32'd1);
      check("samples_left", sb.size(), 32'd0);
      sb.delete();
      exp_cnt++;
      check("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      check("aborted_clear", 32'(o_aborted), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      bit   pat[8];
      int   pulses;
      vecs = '{'{4, 0, 5}, '{3, 2, 8}, '{1, 0, 2}, '{0, 0, 1}, '{3, 1, 6}, '{2, 15, 18}, '{255, 0, 256}};
      pat  = '{1, 0, 0, 1, 1, 0, 1, 1};

      // Reset state with start/ready asserted: everything must stay quiet.
      ready = 1'b1;
      start = 1'b1;
      len   = 8'd4;
      #12;
      check("rst_en", 32'(o_en), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_idx", 32'(o_idx), 32'd0);
      check("rst_aborted", 32'(o_aborted), 32'd0);
      check("rst_cnt", 32'(o_frame_cnt), 32'd0);
      start = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_frame(vecs[i].len, vecs[i].gap, vecs[i].done_off);

      // len=5 with ready toggling: o_en follows ready, idx holds on stalls.
      start  = 1'b1;
      len    = 8'd5;
      gap    = 4'd0;
      ready  = 1'b0;
      step();
      start  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         ready = pat[i];
         @(negedge clk);
         check("tog_en", 32'(o_en), 32'(pat[i]));
         check("tog_idx", 32'(o_idx), pulses);
         check("tog_sof", 32'(o_sof), 32'(pat[i] && pulses == 0));
         check("tog_eof", 32'(o_eof), 32'(pat[i] && pulses == 4));
         if (pat[i]) pulses++;
         step();
      end
      ready = 1'b1;
      @(negedge clk);
      check("tog_done", 32'(o_done), 32'd1);
      step();
      exp_cnt++;
      check("tog_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

      // Abort on the 3rd sample of a len=10 frame.
      start = 1'b1;
      len   = 8'd10;
      gap   = 4'd0;
      step();
      start = 1'b0;
      @(negedge clk);
      check("ab_idx0", 32'(o_idx), 32'd0);
      step();
      @(negedge clk);
      check("ab_idx1", 32'(o_idx), 32'd1);
      step();
      abort = 1'b1;
      @(negedge clk);
      check("ab_en", 32'(o_en), 32'd0);
      check("ab_busy", 32'(o_busy), 32'd1);
      step();
      abort = 1'b0;
      @(negedge clk);
      check("ab_done", 32'(o_done), 32'd1);
      check("ab_aborted", 32'(o_aborted), 32'd1);
      check("ab_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      step();
      @(negedge clk);
      check("ab_idle_done", 32'(o_done), 32'd0);
      check("ab_held", 32'(o_aborted), 32'd1);
      run_frame(1, 0, 2);

      // Start held high through RUN and DONE: only re-accepted from IDLE.
      start = 1'b1;
      len   = 8'd2;
      gap   = 4'd0;
      step();
      @(negedge clk);
      check("hold_sof", 32'(o_sof), 32'd1);
      step();
      @(negedge clk);
      check("hold_eof", 32'(o_eof), 32'd1);
      step();
      @(negedge clk);
      check("hold_done", 32'(o_done), 32'd1);
      check("hold_done_busy", 32'(o_busy), 32'd0);
      step();
      exp_cnt++;
      @(negedge clk);
      check("hold_idle_busy", 32'(o_busy), 32'd0);
      check("hold_idle_done", 32'(o_done), 32'd0);
      step();
      start = 1'b0;
      @(negedge clk);
      check("hold_restart", 32'(o_sof), 32'd1);
      step();
      step();
      @(negedge clk);
      check("hold_done2", 32'(o_done), 32'd1);
      step();
      exp_cnt++;
      check("hold_cnt", 32'(o_frame_cnt), 32'(exp_cnt));

      // Asynchronous reset while in GAP.
      start = 1'b1;
      len   = 8'd3;
      gap   = 4'd5;
      step();
      start = 1'b0;
      step();
      check("gap_busy", 32'(o_busy), 32'd1);
      check("gap_en", 32'(o_en), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt = '0;
      check("arst_busy", 32'(o_busy), 32'd0);
      check("arst_en", 32'(o_en), 32'd0);
      check("arst_done", 32'(o_done), 32'd0);
      check("arst_cnt", 32'(o_frame_cnt), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      run_frame(2, 0, 3);

      // Counter wrap: 256 completed frames since reset.
      for (int i = 0; i < 255; i++) run_frame(0, 0, 1);
      check("cnt_wrap", 32'(o_frame_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
